// File: rtl/aucohl_fifo_ctl.sv
// aucohl_fifo_ctl: single-clock show-ahead FIFO with level count, programmable thresholds,
// synchronous flush and sticky overflow/underflow flags. Define AUCOHL_FIFO_PEAK_EN to add peak/clr_peak.
module aucohl_fifo_ctl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  input  logic          flush,
  input  logic          clr_err,
  input  logic [AW:0]   af_thresh,
  input  logic [AW:0]   ae_thresh,
`ifdef AUCOHL_FIFO_PEAK_EN
  input  logic          clr_peak,
  output logic [AW:0]   peak,
`endif
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          ovf,
  output logic          udf
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] w_ptr;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   level_nxt;
  logic          rd_en;
  logic          wr_en;
  logic          ovf_evt;
  logic          udf_evt;

  assign empty        = (level == '0);
  assign full         = (level == LVL_FULL);
  assign almost_full  = (level >= af_thresh);
  assign almost_empty = (level <= ae_thresh);
  assign rdata        = mem[r_ptr];

  // A pending read frees the slot a write needs, so a full FIFO still accepts rd & wr together.
  assign rd_en   = rd && !empty && !flush;
  assign wr_en   = wr && (!full || rd) && !flush;
  assign ovf_evt = wr && full && !rd && !flush;
  assign udf_evt = rd && empty && !flush;

  always_comb begin
    level_nxt = level;
    if (flush)
      level_nxt = '0;
    else if (wr_en && !rd_en)
      level_nxt = level + LVL_ONE;
    else if (rd_en && !wr_en)
      level_nxt = level - LVL_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
      level <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      level <= level_nxt;
      // A new error event outranks clr_err in the same cycle.
      ovf   <= ovf_evt | (ovf & ~clr_err);
      udf   <= udf_evt | (udf & ~clr_err);
      if (flush) begin
        w_ptr <= '0;
        r_ptr <= '0;
      end else begin
        if (wr_en) w_ptr <= w_ptr + 1'b1;
        if (rd_en) r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[w_ptr] <= wdata;
  end

`ifdef AUCOHL_FIFO_PEAK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      peak <= '0;
    else if (clr_peak || (level_nxt > peak))
      peak <= level_nxt;
  end
`endif

endmodule

// File: tb/tb_aucohl_fifo_ctl.sv
// Randomized and directed bench for aucohl_fifo_ctl (DW=8, AW=4) against a queue-based reference model.
`timescale 1ns/1ps
module tb_aucohl_fifo_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] wdata = '0;
  logic       rd = 1'b0;
  logic [7:0] rdata;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic       clr_peak = 1'b0;
  logic [4:0] af_thresh = 5'd0;
  logic [4:0] ae_thresh = 5'd0;
  logic       empty, full, almost_full, almost_empty, ovf, udf;
  logic [4:0] level;
`ifdef AUCOHL_FIFO_PEAK_EN
  logic [4:0] peak;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue contents, sticky flags, peak since reset / clr_peak.
  logic [7:0] q[$];
  bit m_ovf = 0;
  bit m_udf = 0;
  int m_peak = 0;

  aucohl_fifo_ctl #(.DW(8), .AW(4)) dut (
    .clk(clk), .rst(rst), .wr(wr), .wdata(wdata), .rd(rd), .rdata(rdata),
    .flush(flush), .clr_err(clr_err), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
`ifdef AUCOHL_FIFO_PEAK_EN
    .clr_peak(clr_peak), .peak(peak),
`endif
    .empty(empty), .full(full), .level(level), .almost_full(almost_full),
    .almost_empty(almost_empty), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, need $finish before 500000ns");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, need %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("level", 32'(level), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 16));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= int'(af_thresh)));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= int'(ae_thresh)));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
    if (q.size() > 0) chk("rdata", 32'(rdata), 32'(q[0]));
`ifdef AUCOHL_FIFO_PEAK_EN
    chk("peak", 32'(peak), 32'(m_peak));
`endif
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f, input bit c, input bit cp);
    int  sz;
    bit  ovf_ev, udf_ev;
    wr = w; wdata = d; rd = r; flush = f; clr_err = c; clr_peak = cp;
    sz = q.size();
    @(posedge clk);
    ovf_ev = w && (sz == 16) && !r && !f;
    udf_ev = r && (sz == 0) && !f;
    if (f) q.delete();
    else begin
      if (r && sz > 0) void'(q.pop_front());
      if (w && (sz < 16 || r)) q.push_back(d);
    end
    m_ovf = ovf_ev || (m_ovf && !c);
    m_udf = udf_ev || (m_udf && !c);
    if (cp || q.size() > m_peak) m_peak = q.size();
    #1;
    wr = 0; rd = 0; flush = 0; clr_err = 0; clr_peak = 0;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    m_peak = 0;
  endtask

  initial begin
    // Reset state, with af_thresh 0 so almost_full is asserted out of reset.
    #2;
    check_all();
    chk("rst_almost_full", 32'(almost_full), 32'd1);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    af_thresh = 5'd16;
    ae_thresh = 5'd0;
    #10 rst = 1'b0;

    // Fill with 0x01..0x10, then drain in order.
    for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0, 0, 0);
    chk("t1_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0, 0);
    chk("t1_empty", 32'(empty), 32'd1);

    // Simultaneous rd & wr while full.
    for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0, 0, 0, 0);
    step(1, 8'hAA, 1, 0, 0, 0);
    chk("t2_full_hold", 32'(level), 32'd16);
    chk("t2_no_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0, 0, 0);
    chk("t2_last_aa", 32'(rdata), 32'hAA);
    step(0, 8'h00, 1, 0, 0, 0);

    // rd & wr on empty, then clr_err behaviour.
    step(1, 8'h55, 1, 0, 0, 0);
    chk("t3_rdata_55", 32'(rdata), 32'h55);
    chk("t3_udf_set", 32'(udf), 32'd1);
    step(0, 8'h00, 0, 0, 1, 0);
    chk("t3_udf_clr", 32'(udf), 32'd0);
    step(0, 8'h00, 1, 0, 0, 0);
    step(0, 8'h00, 1, 0, 1, 0);
    chk("t3_udf_wins", 32'(udf), 32'd1);

    // Thresholds.
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    for (int i = 0; i < 12; i++) begin
      step(1, 8'($urandom), 0, 0, 0, 0);
      if (i == 2) chk("t4_ae_at3", 32'(almost_empty), 32'd1);
      if (i == 3) chk("t4_ae_fall", 32'(almost_empty), 32'd0);
      if (i == 10) chk("t4_af_at11", 32'(almost_full), 32'd0);
    end
    chk("t4_af_rise", 32'(almost_full), 32'd1);
    af_thresh = 5'd17;
    ae_thresh = 5'd20;
    #1;
    chk("t4_af_over", 32'(almost_full), 32'd0);
    chk("t4_ae_over", 32'(almost_empty), 32'd1);
    af_thresh = 5'd16;
    ae_thresh = 5'd0;

    // Flush at level 9 with a write pending.
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0, 0);
    chk("t5_level9", 32'(level), 32'd9);
    step(1, 8'h77, 1, 1, 0, 0);
    chk("t5_flush_lvl", 32'(level), 32'd0);
    chk("t5_flush_udf", 32'(udf), 32'd1);
    step(1, 8'h3C, 0, 0, 0, 0);
    chk("t5_rdata_3c", 32'(rdata), 32'h3C);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t6_rst_level", 32'(level), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    check_all();
    #2 rst = 1'b0;

`ifdef AUCOHL_FIFO_PEAK_EN
    for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 0, 0);
    chk("t6_peak10", 32'(peak), 32'd10);
    step(0, 8'h00, 0, 0, 0, 1);
    chk("t6_peak4", 32'(peak), 32'd4);
`endif

    // Randomized phase with alternating fill / drain bias.
    for (int n = 0; n < 2000; n++) begin
      int pw, pr;
      if (n % 50 == 0) begin
        af_thresh = 5'($urandom_range(0, 20));
        ae_thresh = 5'($urandom_range(0, 20));
      end
      pw = ((n / 150) % 2 == 0) ? 80 : 25;
      pr = ((n / 150) % 2 == 0) ? 25 : 80;
      step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
           $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
